// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_pkg
//  Brief    : Shared encodings and helpers for the program-counter generator
//  Revision : 1.0  initial release
// ============================================================================
package pc_pkg;

  // Next-pc source select encodings
  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_IMM = 2'b01;
  localparam logic [1:0] PC_SEL_ALU = 2'b10;
  localparam logic [1:0] PC_SEL_RET = 2'b11;

  // A redirect target is usable only when it is word aligned
  function automatic logic is_misaligned(input logic [1:0] lo_bits);
    return lo_bits != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
//  Module   : pc_ras
//  Brief    : Circular return-address stack; a push when full overwrites the
//             oldest entry, a pop when empty does nothing
//  Revision : 1.0  initial release
// ============================================================================
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int unsigned      PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] stack_q [RAS_DEPTH];
  logic [ADDR_W-1:0] stack_d [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;   // next slot to write; top is ptr_q-1
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Pointer/count/array update; the pointer wraps naturally since depth is 2^n
  always_comb begin
    stack_d = stack_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (push) begin
      stack_d[ptr_q] = push_data;
      ptr_d          = ptr_q + PTR_W'(1);
      if (cnt_q != C_DEPTH) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && (cnt_q != '0)) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers; reset empties the stack
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are meaningless while the count excludes them
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign top   = stack_q[ptr_q - PTR_W'(1)];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == C_DEPTH);

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pc_gen
//  Brief    : Program-counter generator with fetch handshake, trap vector,
//             EPC capture, misaligned-target detection and return stack
//  Revision : 1.0  initial release
// ============================================================================
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned TRAP_VEC  = 'h7F0,
  parameter int unsigned INC       = 4,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_en,
  input  logic [1:0]        pc_sel,
  input  logic [ADDR_W-1:0] imm_addr,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic              call,
  input  logic              trap_req,
  input  logic              pc_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] epc,
  output logic              misalign,
  output logic              ras_empty,
  output logic              ras_full
);

  localparam logic [ADDR_W-1:0] C_RESET = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] C_TRAP  = ADDR_W'(TRAP_VEC);
  localparam logic [ADDR_W-1:0] C_INC   = ADDR_W'(INC);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              pc_valid_q, pc_valid_d;
  logic              misalign_q, misalign_d;

  logic              fire;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic              ras_push, ras_pop;
  logic [ADDR_W-1:0] ras_top;

  assign fire   = pc_valid_q & pc_ready;
  assign pc_inc = pc_q + C_INC;   // wraps modulo 2^ADDR_W

  // Next-pc selection in priority order: trap, jump, return, sequential
  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    pc_valid_d = 1'b1;
    misalign_d = 1'b0;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    target     = (pc_sel == PC_SEL_IMM) ? imm_addr : alu_addr;

    if (trap_req) begin
      pc_d  = C_TRAP;
      epc_d = pc_q;
    end else if (pc_en && ((pc_sel == PC_SEL_IMM) || (pc_sel == PC_SEL_ALU))) begin
      if (is_misaligned(target[1:0])) begin
        pc_d       = C_TRAP;
        epc_d      = pc_q;
        misalign_d = 1'b1;
      end else begin
        pc_d     = target;
        ras_push = call;
      end
    end else if (pc_en && (pc_sel == PC_SEL_RET)) begin
      if (!ras_empty) begin
        pc_d    = ras_top;
        ras_pop = 1'b1;
      end else if (is_misaligned(alu_addr[1:0])) begin
        // Empty stack falls back to the jalr-style target, checked like one
        pc_d       = C_TRAP;
        epc_d      = pc_q;
        misalign_d = 1'b1;
      end else begin
        pc_d = alu_addr;
      end
    end else if (fire) begin
      pc_d = pc_inc;
    end
  end

  // Architectural registers; reset discards any in-flight state
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= C_RESET;
      epc_q      <= '0;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      pc_valid_q <= pc_valid_d;
      misalign_q <= misalign_d;
    end
  end

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign epc      = epc_q;
  assign misalign = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_gen
//  Brief    : Self-checking bench for pc_gen: directed scenarios followed by
//             randomized traffic against a queue-based reference model
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_gen;

  localparam int ADDR_W = 11;
  localparam int MOD    = 1 << ADDR_W;
  localparam int TRAP   = 'h7F0;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              pc_en;
  logic [1:0]        pc_sel;
  logic [ADDR_W-1:0] imm_addr;
  logic [ADDR_W-1:0] alu_addr;
  logic              call;
  logic              trap_req;
  logic              pc_ready;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic [ADDR_W-1:0] epc;
  logic              misalign;
  logic              ras_empty;
  logic              ras_full;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_pc, m_epc, m_valid, m_mis;
  int m_ras[$];

  pc_gen #(
    .ADDR_W    (ADDR_W),
    .RESET_VEC (0),
    .TRAP_VEC  (TRAP),
    .INC       (4),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_en     (pc_en),
    .pc_sel    (pc_sel),
    .imm_addr  (imm_addr),
    .alu_addr  (alu_addr),
    .call      (call),
    .trap_req  (trap_req),
    .pc_ready  (pc_ready),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .epc       (epc),
    .misalign  (misalign),
    .ras_empty (ras_empty),
    .ras_full  (ras_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] sel, input int imm,
                       input int alu, input logic cl, input logic tr, input logic rdy);
    pc_en    = en;
    pc_sel   = sel;
    imm_addr = ADDR_W'(imm);
    alu_addr = ADDR_W'(alu);
    call     = cl;
    trap_req = tr;
    pc_ready = rdy;
  endtask

  // Advance the model by one clock from the currently driven inputs,
  // then step the DUT and compare every output against the model.
  task automatic cyc();
    int tgt;
    if (rst) begin
      m_pc = 0; m_epc = 0; m_valid = 0; m_mis = 0;
      m_ras.delete();
    end else begin
      int cur = m_pc;
      int fire = (m_valid != 0) && pc_ready;
      m_valid = 1;
      m_mis   = 0;
      tgt = -1;
      if (trap_req) begin
        m_pc = TRAP; m_epc = cur;
      end else if (pc_en && (pc_sel == 2'd1 || pc_sel == 2'd2)) begin
        tgt = (pc_sel == 2'd1) ? int'(imm_addr) : int'(alu_addr);
      end else if (pc_en && pc_sel == 2'd3) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else tgt = int'(alu_addr);
      end else if (fire) begin
        m_pc = (cur + 4) % MOD;
      end
      if (tgt >= 0) begin
        if (tgt % 4 != 0) begin
          m_pc = TRAP; m_epc = cur; m_mis = 1;
        end else begin
          m_pc = tgt;
          if (call && pc_sel != 2'd3) begin
            m_ras.push_back((cur + 4) % MOD);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
          end
        end
      end
    end
    @(posedge clk);
    #1;
    check("pc",        int'(pc),        m_pc);
    check("pc_valid",  int'(pc_valid),  m_valid);
    check("epc",       int'(epc),       m_epc);
    check("misalign",  int'(misalign),  m_mis);
    check("ras_empty", int'(ras_empty), int'(m_ras.size() == 0));
    check("ras_full",  int'(ras_full),  int'(m_ras.size() == DEPTH));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 2'd0, 0, 0, 0, 0, 0);
    cyc();
    check("reset_pc", int'(pc), 0);
    check("reset_valid", int'(pc_valid), 0);
    check("reset_empty", int'(ras_empty), 1);
    rst = 1'b0;

    // Sequential fetch
    drive(0, 2'd0, 0, 0, 0, 0, 1);
    cyc(); check("seq0", int'(pc), 'h000); check("valid1", int'(pc_valid), 1);
    cyc(); check("seq1", int'(pc), 'h004);
    cyc(); check("seq2", int'(pc), 'h008);
    // Stall holds, redirect during stall still taken
    drive(0, 2'd0, 0, 0, 0, 0, 0);
    cyc(); check("stall_hold", int'(pc), 'h008);
    drive(1, 2'd1, 'h100, 0, 0, 0, 0);
    cyc(); check("stall_redir", int'(pc), 'h100);
    // Call then return
    drive(1, 2'd1, 'h010, 0, 0, 0, 1); cyc();
    drive(1, 2'd2, 0, 'h200, 1, 0, 1);
    cyc(); check("call_pc", int'(pc), 'h200); check("call_nonempty", int'(ras_empty), 0);
    drive(1, 2'd3, 0, 0, 0, 0, 1);
    cyc(); check("ret_pc", int'(pc), 'h014); check("ret_empty", int'(ras_empty), 1);
    // Five calls overflow a four-deep stack
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'd1, 'h400 + 16 * i, 0, 1, 0, 1); cyc();
    end
    check("ovf_full", int'(ras_full), 1);
    drive(1, 2'd3, 0, 'h300, 0, 0, 1);
    cyc(); check("lifo0", int'(pc), 'h434);
    cyc(); check("lifo1", int'(pc), 'h424);
    cyc(); check("lifo2", int'(pc), 'h414);
    cyc(); check("lifo3", int'(pc), 'h404);
    cyc(); check("ret_fallback", int'(pc), 'h300);
    // Misaligned jump traps without pushing
    drive(1, 2'd1, 'h040, 0, 0, 0, 1); cyc();
    drive(1, 2'd1, 'h102, 0, 1, 0, 1);
    cyc(); check("mis_pc", int'(pc), TRAP); check("mis_epc", int'(epc), 'h040);
    check("mis_pulse", int'(misalign), 1); check("mis_nopush", int'(ras_empty), 1);
    drive(0, 2'd0, 0, 0, 0, 0, 1);
    cyc(); check("mis_drop", int'(misalign), 0);
    // Trap beats a concurrent jump
    drive(1, 2'd1, 'h500, 0, 0, 0, 1); cyc();
    drive(1, 2'd1, 'h100, 0, 0, 1, 1);
    cyc(); check("trap_pc", int'(pc), TRAP); check("trap_epc", int'(epc), 'h500);
    // Wrap at top of address space
    drive(1, 2'd1, 'h7FC, 0, 0, 0, 1); cyc();
    drive(0, 2'd0, 0, 0, 0, 0, 1);
    cyc(); check("wrap", int'(pc), 'h000);
    // Reset while stalled with stack contents
    drive(1, 2'd1, 'h120, 0, 1, 0, 0); cyc();
    drive(0, 2'd0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    cyc(); check("mid_rst_pc", int'(pc), 0); check("mid_rst_empty", int'(ras_empty), 1);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int imm_r = int'($urandom_range(0, MOD - 1));
      int alu_r = int'($urandom_range(0, MOD - 1));
      if ($urandom_range(0, 3) != 0) imm_r = imm_r & ~3;
      if ($urandom_range(0, 3) != 0) alu_r = alu_r & ~3;
      drive(logic'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), imm_r, alu_r,
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 15) == 0),
            logic'($urandom_range(0, 3) != 0));
      rst = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
